// File: rtl/spi_slave.sv
// SPI mode-0 responder: 16-bit frames in on mosi, 8-bit response out on miso.
// Every SPI pin is oversampled in the clk domain; nothing is clocked by sclk.
module spi_slave #(
    parameter int FRAME_BITS  = 16,
    parameter int RESP_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  mosi,
    input  logic                  cs,
    output logic                  miso,
    input  logic [RESP_BITS-1:0]  tx_byte,
    output logic [FRAME_BITS-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  frame_err
);

    localparam int CNT_W = $clog2(FRAME_BITS + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                  state;
    logic [SYNC_STAGES-1:0]  sclk_sync, cs_sync, mosi_sync;
    logic                    sclk_d, cs_d;
    logic [SYNC_STAGES:0]    warm_pipe;
    logic                    armed;
    logic [FRAME_BITS-1:0]   tx_shift, rx_shift, tx_load;
    logic [CNT_W-1:0]        bit_cnt;

    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise =  sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s &  sclk_d;
    assign cs_fall   = ~cs_s   &  cs_d;
    assign cs_rise   =  cs_s   & ~cs_d;

    assign tx_load = FRAME_BITS'(tx_byte) << (FRAME_BITS - RESP_BITS);
    assign busy    = (state != IDLE);
    assign miso    = (state == SHIFT) & tx_shift[FRAME_BITS-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
        end
    end

    // The synchronizers come out of reset reading cs high, so a cs that is
    // already low would look like a fresh fall. Only arm once the pipe has
    // flushed and cs is genuinely seen high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            warm_pipe <= '0;
            armed     <= 1'b0;
        end else begin
            warm_pipe <= {warm_pipe[SYNC_STAGES-1:0], 1'b1};
            if (warm_pipe[SYNC_STAGES] && cs_s)
                armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            tx_shift  <= '0;
            rx_shift  <= '0;
            bit_cnt   <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (cs_fall && armed) begin
                        tx_shift <= tx_load;
                        rx_shift <= '0;
                        bit_cnt  <= '0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    // cs_rise wins even against the final sclk rise
                    if (cs_rise) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                    end else if (sclk_rise) begin
                        rx_shift <= {rx_shift[FRAME_BITS-2:0], mosi_s};
                        bit_cnt  <= bit_cnt + CNT_W'(1);
                        if (bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
                            rx_data  <= {rx_shift[FRAME_BITS-2:0], mosi_s};
                            rx_valid <= 1'b1;
                            state    <= DONE;
                        end
                    end else if (sclk_fall) begin
                        tx_shift <= tx_shift << 1;
                    end
                end
                DONE: begin
                    if (cs_rise)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: mode-0 master model, rx word scoreboard,
// miso checked at every master sampling edge.
module tb_spi_slave;

    localparam time HALF = 100ns;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sclk = 1'b0;
    logic        mosi = 1'b0;
    logic        cs = 1'b1;
    logic        miso;
    logic [7:0]  tx_byte = 8'h00;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        busy;
    logic        frame_err;

    int vec_cnt = 0;
    int err_cnt = 0;
    int rv_cnt  = 0;
    int fe_cnt  = 0;
    int rv0, fe0;
    logic [15:0] sb[$];

    spi_slave dut (
        .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .cs(cs), .miso(miso),
        .tx_byte(tx_byte), .rx_data(rx_data), .rx_valid(rx_valid),
        .busy(busy), .frame_err(frame_err)
    );

    always #5ns clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every rx_valid must match the oldest queued word.
    always @(negedge clk) begin
        if (rx_valid) begin
            rv_cnt++;
            if (sb.size() == 0) check("rx_valid_unexpected", 32'd1, 32'd0);
            else check("rx_word", rx_data, sb.pop_front());
        end
        if (frame_err) fe_cnt++;
    end

    task automatic cs_low(input logic [7:0] txb);
        @(negedge clk);
        tx_byte = txb;
        cs = 1'b0;
        repeat (6) @(negedge clk);
        check("busy_in_frame", busy, 1'b1);
    endtask

    task automatic cs_high();
        @(negedge clk);
        cs = 1'b1;
        repeat (6) @(negedge clk);
        check("busy_after_frame", busy, 1'b0);
    endtask

    task automatic send(input logic [15:0] w, input logic [7:0] txb, input int nb,
                        input bit push, input bit chk_miso, input bit cs_on_last);
        logic exp_m;
        if (push) sb.push_back(w);
        for (int i = 0; i < nb; i++) begin
            mosi = (i < 16) ? w[15-i] : 1'b0;
            #(HALF);
            if (chk_miso) begin
                if (i < 8) exp_m = txb[7-i];
                else exp_m = 1'b0;
                check($sformatf("miso_bit%0d", i), miso, exp_m);
            end
            sclk = 1'b1;
            if (cs_on_last && i == nb - 1) cs = 1'b1;
            #(HALF);
            sclk = 1'b0;
        end
    endtask

    task automatic mark();
        rv0 = rv_cnt;
        fe0 = fe_cnt;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_rx_data", rx_data, 16'h0);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_miso", miso, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        rst = 1'b1;
        repeat (10) @(negedge clk);

        // Normal frame
        mark();
        cs_low(8'hA5);
        send(16'h3C7E, 8'hA5, 16, 1, 1, 0);
        cs_high();
        check("normal_rx_data", rx_data, 16'h3C7E);
        check("normal_rv_cnt", rv_cnt - rv0, 1);
        check("normal_fe_cnt", fe_cnt - fe0, 0);

        // Back-to-back frames with tx_byte changed between them
        mark();
        cs_low(8'hA5);
        send(16'h0001, 8'hA5, 16, 1, 1, 0);
        cs_high();
        cs_low(8'h5A);
        send(16'hFFFF, 8'h5A, 16, 1, 1, 0);
        cs_high();
        check("b2b_rx_data", rx_data, 16'hFFFF);
        check("b2b_rv_cnt", rv_cnt - rv0, 2);

        // Abort after 9 bits
        mark();
        cs_low(8'h3C);
        send(16'h1234, 8'h3C, 9, 0, 1, 0);
        cs_high();
        check("abort_fe_cnt", fe_cnt - fe0, 1);
        check("abort_rv_cnt", rv_cnt - rv0, 0);
        check("abort_rx_hold", rx_data, 16'hFFFF);
        cs_low(8'hC7);
        send(16'hBEEF, 8'hC7, 16, 1, 1, 0);
        cs_high();
        check("after_abort_rx", rx_data, 16'hBEEF);

        // 18 sclk pulses in one frame
        mark();
        cs_low(8'hFF);
        send(16'h55AA, 8'hFF, 18, 1, 1, 0);
        cs_high();
        check("extra_rx_data", rx_data, 16'h55AA);
        check("extra_rv_cnt", rv_cnt - rv0, 1);
        check("extra_fe_cnt", fe_cnt - fe0, 0);

        // Reset mid-frame, released with cs still low
        mark();
        cs_low(8'hA5);
        send(16'hFFFF, 8'hA5, 6, 0, 1, 0);
        rst = 1'b0;
        #1ns;
        check("midrst_rx_data", rx_data, 16'h0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_miso", miso, 1'b0);
        check("midrst_rx_valid", rx_valid, 1'b0);
        check("midrst_frame_err", frame_err, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("midrst_not_joined", busy, 1'b0);
        send(16'hFFFF, 8'h00, 10, 0, 1, 0);
        cs_high();
        check("midrst_rv_cnt", rv_cnt - rv0, 0);
        check("midrst_fe_cnt", fe_cnt - fe0, 0);
        cs_low(8'h96);
        send(16'hC3C3, 8'h96, 16, 1, 1, 0);
        cs_high();
        check("midrst_next_rx", rx_data, 16'hC3C3);
        check("midrst_next_rv", rv_cnt - rv0, 1);

        // cs rise coinciding with the 16th sclk rise
        mark();
        cs_low(8'h3C);
        send(16'h9999, 8'h3C, 16, 0, 1, 1);
        cs_high();
        check("simul_fe_cnt", fe_cnt - fe0, 1);
        check("simul_rv_cnt", rv_cnt - rv0, 0);
        check("simul_rx_hold", rx_data, 16'hC3C3);

        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
# spi_slave

SPI responder for the board-to-board link driven by the team's SPI master. It receives 16-bit frames on `mosi` and returns an 8-bit response byte on `miso`, all in SPI mode 0 (CPOL=0, CPHA=0), MSB first. All SPI pins are oversampled in the `clk` domain, with no logic clocked by `sclk`. Received words go to downstream logic (counter display / register file) through a one-cycle `rx_valid` strobe.

## Interface
- `FRAME_BITS`, 16: bits per frame sampled from `mosi`.
- `RESP_BITS`, 8: response bits driven on `miso` at the start of the frame; must be ≤ `FRAME_BITS`.
- `SYNC_STAGES`, 2: flip-flop stages on each of `sclk`, `cs`, `mosi`; minimum 2.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `sclk`  in  1  SPI clock from master, asynchronous to `clk`.
- `mosi`  in  1  serial data from master.
- `cs`  in  1  chip select, active-low.
- `miso`  out  1  serial data to master.
- `tx_byte`  in  `RESP_BITS`  response byte, captured at frame start.
- `rx_data`  out  `FRAME_BITS`  last complete received frame.
- `rx_valid`  out  1  one-cycle strobe when `rx_data` updates.
- `busy`  out  1  high while a frame is in progress.
- `frame_err`  out  1  one-cycle strobe when a frame is aborted.

## Operation
- Each of `sclk`, `cs` and `mosi` passes through a `SYNC_STAGES` synchronizer.
- One further register per signal feeds the edge detectors: `sclk_rise`, `sclk_fall`, `cs_fall`, `cs_rise`.
- The FSM has three states: IDLE, SHIFT, DONE.
- **IDLE**
  - On `cs_fall`: load the `tx_shift` register with `{tx_byte, zeros}` (width `FRAME_BITS`).
  - Drive `miso` from `tx_shift` MSB. CPHA=0 requires bit 15 valid before the first rising edge.
  - Clear `bit_cnt` (5 bits) and go to SHIFT.
  - `sclk` edges in IDLE are ignored.
- **SHIFT**
  - On `sclk_rise`: `rx_shift <= {rx_shift[FRAME_BITS-2:0], mosi_sync}` and `bit_cnt++`.
  - On `sclk_fall`: `tx_shift <<= 1`, so `miso` presents the next bit.
  - When `bit_cnt` reaches `FRAME_BITS` on a rise: `rx_data <= shifted word` and pulse `rx_valid`, then go to DONE.
  - On `cs_rise` with `bit_cnt` < `FRAME_BITS`: pulse `frame_err`, leave `rx_data` unchanged, go to IDLE.
- **DONE**
  - Extra `sclk` edges are ignored and `miso` = 0.
  - On `cs_rise`, go to IDLE. No error is flagged.
- **Outputs**
  - `busy` = (state != IDLE).
  - `miso` = 0 whenever the state is not SHIFT, and also after all `RESP_BITS` have been shifted out.
  - `miso` is never tri-stated; this is a single-slave link.
- **Priority in a single `clk` cycle**
  - `cs_rise` beats `sclk_rise`. If they coincide on the 16th edge, the frame is aborted and `frame_err` pulses.
  - `cs_fall` in IDLE cannot coincide with a valid data edge; mode 0 has `sclk` low at that point.
- **Reset** (asynchronous, any time, including mid-frame)
  - State → IDLE. `rx_data` = 0, `rx_valid` = 0, `frame_err` = 0, `busy` = 0, `miso` = 0.
  - Shift registers, counter and synchronizers are cleared; synchronizers clear to `cs` high and `sclk` low.
  - If `cs` is still low after reset release, the block waits for the next `cs_fall` and does not join the partial frame.

## Timing
- `sclk` frequency must be ≤ `clk`/8.
- `cs` setup to the first `sclk` rise must be ≥ 4 `clk` periods.
- Edge detect latency is `SYNC_STAGES`+1 `clk` cycles from the pin (3 at default).
- `miso` changes 3–4 `clk` cycles after each `sclk` falling edge, and after `cs` falling for bit 15. This is within the half-period margin given the ratio above.
- `rx_valid` rises 3 `clk` cycles after the 16th `sclk` rise at the pin and is exactly 1 cycle wide.
- `rx_data` is stable from that cycle until the next `rx_valid`.
- `frame_err` rises 3 cycles after `cs` rises at the pin and is 1 cycle wide.
- Back-to-back frames are allowed with ≥ 4 `clk` cycles of `cs` high between them.

## Test plan
- **Normal frame:** `clk`=100 MHz, `sclk`=5 MHz, `tx_byte`=8'hA5, master sends 16'h3C7E.
  - `rx_data`=16'h3C7E, single `rx_valid` pulse.
  - Master samples `miso` bits 8'hA5 then 8'h00.
  - `busy` is high from `cs_fall` to `cs_rise`.
- **Back-to-back frames:** 16'h0001 then 16'hFFFF with `tx_byte` changed to 8'h5A between them.
  - Two `rx_valid` pulses with the correct words.
  - Second response is 8'h5A.
- **Abort:** `cs` rises after 9 bits of 16'h1234.
  - One `frame_err` pulse, no `rx_valid`, `rx_data` holds the previous value.
  - The next full frame 16'hBEEF is received correctly.
- **Extra clocks:** 18 `sclk` pulses in one frame.
  - `rx_data` = the first 16 bits, exactly one `rx_valid`, no `frame_err`.
  - `miso` = 0 after bit 7.
- **Reset mid-frame:** `rst` low after 6 bits, released while `cs` is still low.
  - All outputs 0 immediately.
  - The remaining bits are ignored with no `rx_valid`.
  - The next `cs`-framed 16'hC3C3 is received correctly.
- **Simultaneous edges:** `cs` rises in the same `clk` cycle as the synchronized 16th `sclk` rise.
  - `frame_err` pulses, no `rx_valid`, `rx_data` unchanged.
